// File: rtl/expu_pkg.sv
// Shared types and helpers for the exponential-unit datapath.
package expu_pkg;

  typedef enum logic [1:0] {FP32, FP16, FP16ALT, FP8} fp_format_e;

  typedef enum logic [1:0] {IDLE, ACC, NORM, OUT} sum_acc_state_e;

  localparam int unsigned FIX_MAX_W = 64;

  typedef struct packed {
    logic                 ovf;
    logic [FIX_MAX_W-1:0] fix;
  } fix_conv_t;

  function automatic int unsigned fp_exp_bits(input fp_format_e fmt);
    case (fmt)
      FP32:    return 8;
      FP16:    return 5;
      FP16ALT: return 8;
      default: return 5;
    endcase
  endfunction

  function automatic int unsigned fp_man_bits(input fp_format_e fmt);
    case (fmt)
      FP32:    return 23;
      FP16:    return 10;
      FP16ALT: return 7;
      default: return 2;
    endcase
  endfunction

  // Truncating float -> unsigned fixed point with frac_bits fraction bits.
  // Negative, zero and denormal inputs give 0; values >= 2.0, inf and NaN
  // give 0 with ovf set. Bits below 2^-frac_bits are dropped.
  function automatic fix_conv_t fp2fix(input logic [31:0] bits,
                                       input int unsigned exp_bits,
                                       input int unsigned man_bits,
                                       input int unsigned frac_bits);
    fix_conv_t            res;
    logic [31:0]          sign_w, exp_f, man_f, exp_max;
    logic [FIX_MAX_W-1:0] sig;
    int                   e, sh;
    res     = '0;
    exp_max = (32'd1 << exp_bits) - 32'd1;
    sign_w  = bits >> (exp_bits + man_bits);
    exp_f   = (bits >> man_bits) & exp_max;
    man_f   = bits & ((32'd1 << man_bits) - 32'd1);
    e       = int'(exp_f) - int'(exp_max >> 1);
    sig     = FIX_MAX_W'(man_f) | (FIX_MAX_W'(1) << man_bits);
    sh      = int'(frac_bits) + e - int'(man_bits);
    if (sign_w[0] || exp_f == 32'd0) res = '0;
    else if (exp_f == exp_max || e >= 1) res.ovf = 1'b1;
    else if (e < -int'(frac_bits)) res = '0;
    else if (sh >= 0) res.fix = sig << sh;
    else res.fix = sig >> (-sh);
    return res;
  endfunction

endpackage

// File: rtl/expu_fix2fp.sv
// Unsigned fixed point -> float with leading-one detect and RNE rounding.
module expu_fix2fp #(
  parameter int unsigned  EXP_BITS = 8,
  parameter int unsigned  MAN_BITS = 7,
  parameter int unsigned  ACC_W    = 35,
  parameter int unsigned  ACC_FRAC = 24,
  localparam int unsigned WIDTH    = 1 + EXP_BITS + MAN_BITS
) (
  input  logic [ACC_W-1:0] fix_i,
  input  logic             ovf_i,
  output logic [WIDTH-1:0] fp_o
);

  localparam int unsigned POS_W   = $clog2(ACC_W);
  localparam int          BIAS    = 2 ** (EXP_BITS - 1) - 1;
  localparam int          EXP_MAX = 2 ** EXP_BITS - 1;

  logic [POS_W-1:0]          lead_pos;
  logic                      nonzero;
  logic [ACC_W-1:0]          norm;
  logic [MAN_BITS-1:0]       man;
  logic                      guard, sticky, round_up;
  int                        exp_b;
  logic [WIDTH-2:0]          mag;

  // Leading-one detect: the highest set bit wins because it is written last.
  always_comb begin
    lead_pos = '0;
    nonzero  = 1'b0;
    for (int i = 0; i < ACC_W; i++) begin
      if (fix_i[i]) begin
        lead_pos = POS_W'(i);
        nonzero  = 1'b1;
      end
    end
  end

  // Normalise so the leading one sits at the MSB, round to nearest even, pack.
  // A mantissa carry ripples straight into the exponent field.
  always_comb begin
    norm     = fix_i << (POS_W'(ACC_W - 1) - lead_pos);
    man      = norm[ACC_W-2 -: MAN_BITS];
    guard    = norm[ACC_W-2-MAN_BITS];
    sticky   = |norm[ACC_W-3-MAN_BITS:0];
    round_up = guard & (sticky | man[0]);
    exp_b    = int'(lead_pos) - int'(ACC_FRAC) + BIAS;
    mag      = {EXP_BITS'(exp_b), man} + (WIDTH-1)'(round_up);
    fp_o     = {1'b0, mag};
    if (ovf_i || exp_b >= EXP_MAX) fp_o = {1'b0, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};
    else if (!nonzero || exp_b <= 0) fp_o = '0;
  end

endmodule

// File: rtl/expu_sum_acc.sv
// Softmax denominator: exact fixed-point sum of a vector of exponentials,
// rounded back to the element format on the last beat.
module expu_sum_acc
  import expu_pkg::*;
#(
  parameter fp_format_e   FPFORMAT = FP16ALT,
  parameter int unsigned  ACC_FRAC = 24,
  parameter int unsigned  MAX_LEN  = 1024,
  localparam int unsigned EXP_BITS = fp_exp_bits(FPFORMAT),
  localparam int unsigned MAN_BITS = fp_man_bits(FPFORMAT),
  localparam int unsigned WIDTH    = 1 + EXP_BITS + MAN_BITS,
  localparam int unsigned INT_BITS = $clog2(MAX_LEN) + 1,
  localparam int unsigned ACC_W    = INT_BITS + ACC_FRAC,
  localparam int unsigned CNT_W    = $clog2(MAX_LEN + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_sum_o,
  output logic [CNT_W-1:0] out_count_o,
  output logic             out_ovf_o,
  output logic             out_trunc_o
);

  sum_acc_state_e   state_q, state_d;
  logic [ACC_W-1:0] acc_p0, acc_nxt;
  logic [CNT_W-1:0] cnt_p0, cnt_nxt;
  logic             ovf_p0, trunc_p0, ovf_nxt, close_nxt;
  logic [WIDTH-1:0] sum_p1, norm_sum;
  logic [CNT_W-1:0] cnt_p1;
  logic             ovf_p1, trunc_p1;
  fix_conv_t        conv;
  logic [ACC_W-1:0] in_fix;
  logic             fix_unused;
  logic             accept, out_done;

  assign in_ready_o = (state_q == IDLE) || (state_q == ACC);
  assign accept     = in_valid_i & in_ready_o & ~clear_i;
  assign out_done   = (state_q == OUT) & out_ready_i;
  assign conv       = fp2fix(32'(in_data_i), EXP_BITS, MAN_BITS, ACC_FRAC);
  assign in_fix     = conv.fix[ACC_W-1:0];
  assign fix_unused = |conv.fix[FIX_MAX_W-1:ACC_W];

  // Next accumulator contents for an accepted beat; IDLE starts a fresh vector.
  always_comb begin
    cnt_nxt   = (state_q == IDLE) ? CNT_W'(1) : cnt_p0 + CNT_W'(1);
    acc_nxt   = ((state_q == IDLE) ? ACC_W'(0) : acc_p0) + in_fix;
    ovf_nxt   = ((state_q == IDLE) ? 1'b0 : ovf_p0) | conv.ovf;
    close_nxt = in_last_i || (cnt_nxt == CNT_W'(MAX_LEN));
  end

  // Next-state logic; clear overrides every transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ACC: if (accept) state_d = close_nxt ? NORM : ACC;
      NORM:      state_d = OUT;
      OUT:       if (out_ready_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // ---- stage p0: accumulate accepted beats ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_p0   <= '0;
      cnt_p0   <= '0;
      ovf_p0   <= 1'b0;
      trunc_p0 <= 1'b0;
    end else if (clear_i || out_done) begin
      acc_p0   <= '0;
      cnt_p0   <= '0;
      ovf_p0   <= 1'b0;
      trunc_p0 <= 1'b0;
    end else if (accept) begin
      acc_p0   <= acc_nxt;
      cnt_p0   <= cnt_nxt;
      ovf_p0   <= ovf_nxt;
      trunc_p0 <= !in_last_i && (cnt_nxt == CNT_W'(MAX_LEN));
    end
  end

  expu_fix2fp #(
    .EXP_BITS (EXP_BITS),
    .MAN_BITS (MAN_BITS),
    .ACC_W    (ACC_W),
    .ACC_FRAC (ACC_FRAC)
  ) u_fix2fp (
    .fix_i (acc_p0),
    .ovf_i (ovf_p0),
    .fp_o  (norm_sum)
  );

  // ---- stage p1: result registers, loaded in NORM and held afterwards ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_p1   <= '0;
      cnt_p1   <= '0;
      ovf_p1   <= 1'b0;
      trunc_p1 <= 1'b0;
    end else if (state_q == NORM && !clear_i) begin
      sum_p1   <= norm_sum;
      cnt_p1   <= cnt_p0;
      ovf_p1   <= ovf_p0;
      trunc_p1 <= trunc_p0;
    end
  end

  assign out_valid_o = (state_q == OUT);
  assign out_sum_o   = sum_p1;
  assign out_count_o = cnt_p1;
  assign out_ovf_o   = ovf_p1;
  assign out_trunc_o = trunc_p1;

endmodule

// File: tb/tb_expu_sum_acc.sv
// Bench for expu_sum_acc (bf16, MAX_LEN=8): directed cases plus random
// vectors checked against an arithmetic model of the exact sum and RNE.
module tb_expu_sum_acc;
  import expu_pkg::*;

  localparam int MAXL = 8;
  localparam int CW   = $clog2(MAXL + 1);

  typedef struct packed {
    logic [2:0]  len;
    logic [63:0] d;
    logic [15:0] sum;
    logic        ovf;
  } dcase_t;

  localparam dcase_t DC [8] = '{
    '{3'd4, 64'h3F80_3F80_3F80_3F80, 16'h4080, 1'b0},
    '{3'd3, 64'h0000_3E80_3F00_3F80, 16'h3FE0, 1'b0},
    '{3'd4, 64'h3B80_3B80_3B80_3F80, 16'h3F82, 1'b0},
    '{3'd1, 64'h0000_0000_0000_0000, 16'h0000, 1'b0},
    '{3'd1, 64'h0000_0000_0000_8000, 16'h0000, 1'b0},
    '{3'd1, 64'h0000_0000_0000_0001, 16'h0000, 1'b0},
    '{3'd2, 64'h0000_0000_4000_3F80, 16'h7F80, 1'b1},
    '{3'd2, 64'h0000_0000_7FC0_3F80, 16'h7F80, 1'b1}
  };

  logic          clk = 1'b0;
  logic          rst_n, clear, in_valid, in_last, out_ready;
  logic          in_ready, out_valid, out_ovf, out_trunc;
  logic [15:0]   in_data, out_sum;
  logic [CW-1:0] out_count;

  int          vectors = 0;
  int          errors  = 0;
  int          cyc     = 0;
  int          last_acc_cyc, valid_cyc;
  bit          timed_out;
  logic [15:0] vec_q[$];

  expu_sum_acc #(.FPFORMAT(FP16ALT), .ACC_FRAC(24), .MAX_LEN(MAXL)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_sum_o   (out_sum),
    .out_count_o (out_count),
    .out_ovf_o   (out_ovf),
    .out_trunc_o (out_trunc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Value in units of 2^-24, truncated; ov flags inputs >= 2.0, inf, NaN.
  function automatic longint to_units(input logic [15:0] v, output bit ov);
    int     ef, sh;
    longint sig;
    ov  = 1'b0;
    ef  = int'(v[14:7]);
    sig = 128 + longint'(v[6:0]);
    if (v[15] || ef == 0) return 0;
    if (ef >= 128) begin ov = 1'b1; return 0; end
    sh = ef - 110;
    return (sh >= 0) ? (sig << sh) : (sig >> (-sh));
  endfunction

  // Exact sum s * 2^-24 rounded to bf16, ties to even.
  function automatic logic [15:0] to_bf16(input longint s, input bit ov);
    int          p;
    longint      q, r, half;
    logic [7:0]  ex;
    if (ov) return 16'h7F80;
    if (s == 0) return 16'h0000;
    p = 0;
    while ((s >> (p + 1)) != 0) p++;
    if (p > 7) begin
      q    = s >> (p - 7);
      r    = s - (q << (p - 7));
      half = longint'(1) << (p - 8);
      if (r > half || (r == half && q[0])) q = q + 1;
    end else begin
      q = s << (7 - p);
    end
    if (q == 256) begin q = 128; p++; end
    ex = 8'(p - 24 + 127);
    return {1'b0, ex, 7'(q)};
  endfunction

  function automatic logic [15:0] rand_val();
    int k;
    k = $urandom_range(0, 9);
    if (k < 7)  return {1'b0, 8'($urandom_range(100, 127)), 7'($urandom)};
    if (k == 7) return 16'($urandom);
    if (k == 8) return {1'b0, 8'($urandom_range(128, 255)), 7'($urandom)};
    return {1'b1, 15'($urandom)};
  endfunction

  task automatic push_vec(input bit mark_last);
    int i, guard;
    bit took;
    i = 0; guard = 0; timed_out = 1'b0;
    while (i < vec_q.size() && !timed_out) begin
      in_valid = 1'b1;
      in_data  = vec_q[i];
      in_last  = mark_last && (i == vec_q.size() - 1);
      took     = in_ready;
      if (took) last_acc_cyc = cyc;
      @(posedge clk); #1;
      if (took) i++;
      guard++;
      if (guard > 64) timed_out = 1'b1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) timed_out = 1'b1;
    valid_cyc = cyc;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    vectors++; if (out_sum !== 16'h0) begin errors++; $display("FAIL reset out_sum: got %h want 0000", out_sum); end
    vectors++; if (out_count !== '0) begin errors++; $display("FAIL reset out_count: got %0d want 0", out_count); end
    vectors++; if (out_ovf !== 1'b0 || out_trunc !== 1'b0) begin errors++; $display("FAIL reset flags: got ovf=%b trunc=%b want 0 0", out_ovf, out_trunc); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    dcase_t dc;
    for (int n = 0; n < 8; n++) begin
      dc = DC[n];
      vec_q.delete();
      for (int k = 0; k < int'(dc.len); k++) vec_q.push_back(dc.d[16*k +: 16]);
      push_vec(1'b1);
      wait_valid();
      vectors++; if (timed_out) begin errors++; $display("FAIL dir%0d timeout: got no result, want out_valid", n); end
      vectors++; if (valid_cyc - last_acc_cyc !== 2) begin errors++; $display("FAIL dir%0d latency: got %0d want 2", n, valid_cyc - last_acc_cyc); end
      vectors++; if (out_sum !== dc.sum) begin errors++; $display("FAIL dir%0d sum: got %h want %h", n, out_sum, dc.sum); end
      vectors++; if (out_count !== CW'(dc.len)) begin errors++; $display("FAIL dir%0d count: got %0d want %0d", n, out_count, dc.len); end
      vectors++; if (out_ovf !== dc.ovf || out_trunc !== 1'b0) begin errors++; $display("FAIL dir%0d flags: got ovf=%b trunc=%b want %b 0", n, out_ovf, out_trunc, dc.ovf); end
      handshake();
      vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d post-handshake: got valid=%b ready=%b want 0 1", n, out_valid, in_ready); end
    end
  endtask

  task automatic test_backpressure();
    vec_q = '{16'h3F80, 16'h3F80};
    push_vec(1'b1);
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_sum !== 16'h4000 || out_count !== CW'(2) || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure hold%0d: got valid=%b sum=%h cnt=%0d ready=%b want 1 4000 2 0", k, out_valid, out_sum, out_count, in_ready);
      end
      @(posedge clk); #1;
    end
    handshake();
    vectors++; if (out_valid !== 1'b0 || out_sum !== 16'h4000 || out_count !== CW'(2)) begin errors++; $display("FAIL backpressure after: got valid=%b sum=%h cnt=%0d want 0 4000 2", out_valid, out_sum, out_count); end
  endtask

  task automatic test_trunc();
    vec_q.delete();
    for (int k = 0; k < MAXL; k++) vec_q.push_back(16'h3F80);
    push_vec(1'b0);
    in_valid = 1'b1; in_data = 16'h3F00; in_last = 1'b1;
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL trunc ready: got %b want 0", in_ready); end
    wait_valid();
    vectors++; if (out_sum !== 16'h4100 || out_count !== CW'(MAXL)) begin errors++; $display("FAIL trunc result: got sum=%h cnt=%0d want 4100 %0d", out_sum, out_count, MAXL); end
    vectors++; if (out_trunc !== 1'b1 || out_ovf !== 1'b0) begin errors++; $display("FAIL trunc flags: got trunc=%b ovf=%b want 1 0", out_trunc, out_ovf); end
    handshake();
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL trunc resume ready: got %b want 1", in_ready); end
    last_acc_cyc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    timed_out = 1'b0;
    wait_valid();
    vectors++; if (timed_out || valid_cyc - last_acc_cyc !== 2) begin errors++; $display("FAIL trunc held beat latency: got %0d want 2", valid_cyc - last_acc_cyc); end
    vectors++; if (out_sum !== 16'h3F00 || out_count !== CW'(1) || out_trunc !== 1'b0) begin errors++; $display("FAIL trunc held beat: got sum=%h cnt=%0d trunc=%b want 3F00 1 0", out_sum, out_count, out_trunc); end
    handshake();
  endtask

  task automatic test_clear();
    vec_q = '{16'h3F80, 16'h3F80};
    push_vec(1'b0);
    in_valid = 1'b1; in_data = 16'h3F80; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clear idle: got ready=%b want 1", in_ready); end
    for (int k = 0; k < 4; k++) begin
      vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear no output %0d: got valid=%b want 0", k, out_valid); end
      @(posedge clk); #1;
    end
    vec_q = '{16'h3F00};
    push_vec(1'b1);
    wait_valid();
    vectors++; if (timed_out || out_sum !== 16'h3F00 || out_count !== CW'(1)) begin errors++; $display("FAIL clear next vector: got sum=%h cnt=%0d want 3F00 1", out_sum, out_count); end
    handshake();
    vec_q = '{16'h3F80};
    push_vec(1'b1);
    wait_valid();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL clear in OUT: got valid=%b ready=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_async_reset();
    vec_q = '{16'h3F80, 16'h3F80};
    push_vec(1'b0);
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (out_sum !== 16'h0 || out_count !== '0 || in_ready !== 1'b1) begin errors++; $display("FAIL async reset: got sum=%h cnt=%0d ready=%b want 0000 0 1", out_sum, out_count, in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    vec_q = '{16'h3E80};
    push_vec(1'b1);
    wait_valid();
    vectors++; if (timed_out || out_sum !== 16'h3E80 || out_count !== CW'(1)) begin errors++; $display("FAIL after async reset: got sum=%h cnt=%0d want 3E80 1", out_sum, out_count); end
    handshake();
  endtask

  task automatic test_random();
    int          len;
    bit          mark_last, ov, any_ov;
    longint      s;
    logic [15:0] exp_sum;
    for (int n = 0; n < 40; n++) begin
      len = $urandom_range(1, MAXL);
      mark_last = (len < MAXL) ? 1'b1 : 1'($urandom_range(0, 1));
      vec_q.delete();
      s = 0; any_ov = 1'b0;
      for (int k = 0; k < len; k++) begin
        vec_q.push_back(rand_val());
        s = s + to_units(vec_q[k], ov);
        any_ov = any_ov | ov;
      end
      exp_sum = to_bf16(s, any_ov);
      push_vec(mark_last);
      wait_valid();
      vectors++; if (timed_out || valid_cyc - last_acc_cyc !== 2) begin errors++; $display("FAIL rnd%0d latency: got %0d want 2", n, valid_cyc - last_acc_cyc); end
      vectors++; if (out_sum !== exp_sum) begin errors++; $display("FAIL rnd%0d sum: got %h want %h", n, out_sum, exp_sum); end
      vectors++; if (out_count !== CW'(len) || out_ovf !== any_ov || out_trunc !== !mark_last) begin
        errors++;
        $display("FAIL rnd%0d cnt/flags: got %0d %b %b want %0d %b %b", n, out_count, out_ovf, out_trunc, len, any_ov, !mark_last);
      end
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      handshake();
    end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_trunc();
    test_clear();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/expu_sum_acc.md
Name: expu_sum_acc

Overview:
Downstream neighbour of the exponential row. Consumes the stream of exponentials produced for one softmax vector and accumulates them in an exact wide fixed-point register. On the last element it normalises and rounds the sum back to FPFORMAT, giving the softmax denominator. The result is presented together with the element count on a valid/ready output.

Parameters:
FPFORMAT, fpnew_pkg::FP16ALT, element format (WIDTH, MANTISSA_BITS, EXPONENT_BITS derived via fpnew_pkg).
ACC_FRAC, 24, fraction bits of the accumulator.
MAX_LEN, 1024, maximum number of elements per vector.
(localparam) INT_BITS = $clog2(MAX_LEN)+1; ACC_W = INT_BITS+ACC_FRAC; CNT_W = $clog2(MAX_LEN+1).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous clear, highest priority
in_valid_i  in  1  input element valid
in_ready_o  out  1  input element accepted when valid&ready
in_data_i  in  WIDTH  exponential value (FPFORMAT)
in_last_i  in  1  marks the final element of a vector
out_valid_o  out  1  result valid
out_ready_i  in  1  result consumed when valid&ready
out_sum_o  out  WIDTH  sum (FPFORMAT, RNE)
out_count_o  out  CNT_W  number of elements accumulated
out_ovf_o  out  1  an input was ≥2.0, inf or NaN; out_sum_o forced to +inf
out_trunc_o  out  1  vector closed at MAX_LEN without in_last_i

Behaviour:
- Reset: state IDLE; accumulator, count and flags are 0.
- Reset outputs: out_valid_o=0, out_sum_o=0, out_count_o=0, out_ovf_o=0, out_trunc_o=0.
- in_ready_o is 1 in IDLE/ACC and 0 in NORM/OUT. It is driven combinationally from the state only.
- Input conversion, combinational, truncating:
  - sign=1, zero or denormal -> 0.
  - Exponent field all ones (inf/NaN), or unbiased exponent ≥ 1 -> contributes 0 and sets the sticky ovf flag.
  - Otherwise the value (1.m)·2^e, e ≤ 0, is placed at fraction LSB weight 2^-ACC_FRAC. Bits below that weight are discarded.
  - e < -ACC_FRAC -> 0.
- The accumulator cannot overflow: at most MAX_LEN values, each < 2.
- FSM:
  - IDLE: an accepted beat loads acc=conv(in), count=1, then goes to ACC. If that beat also has last, go directly to NORM.
  - ACC: each accepted beat does acc+=conv(in), count+=1. A beat with last goes to NORM. The beat that makes count==MAX_LEN without last also goes to NORM and sets trunc.
  - NORM (1 cycle): leading-one detect on acc. Exponent = pos−ACC_FRAC+bias. Mantissa is rounded to nearest, ties to even, with mantissa carry incrementing the exponent. acc==0 -> +0; ovf -> +inf (0x7F80 for bf16). Sum, count and flags are registered into the output regs; goes to OUT.
  - OUT: out_valid_o=1, with all out_* held stable until out_ready_i. On handshake go to IDLE; acc, count and flags are zeroed and out_valid_o drops the next cycle.
- Latency: last beat accepted in cycle t -> out_valid_o high in cycle t+2. Earliest next-vector accept is the cycle after the output handshake.
- Out registers keep their last value after the handshake; only out_valid_o drops.
- clear_i (any state, including mid-vector or OUT): the next state is IDLE. Acc, count, flags and out_valid_o are zeroed; any pending result is discarded. A beat presented during clear_i is not accepted (in_ready_o is unaffected; the beat is dropped).
- Asynchronous reset mid-operation behaves like clear_i, but immediately.

Decomposition:
- Add to expu_pkg: sum_acc_state_e {IDLE, ACC, NORM, OUT}, and a function for the FPFORMAT->fixed conversion (shared with future max/normalise stages).
- Sub-module expu_fix2fp: combinational ACC_W-bit unsigned fixed-point to FPFORMAT converter, with LZC and RNE, parameterised by ACC_W and ACC_FRAC. It is instantiated once, feeding the NORM-stage registers.

Test Plan:
- 4 beats of 0x3F80 (1.0), last on the 4th -> out_sum_o=0x4080 (4.0), count=4, flags 0, out_valid_o exactly 2 cycles after the last accept.
- 0x3F80, 0x3F00, 0x3E80 (last) -> 0x3FE0 (1.75), count=3. Then 0x3F80 plus three 0x3B80 (2^-8, last) -> exact 1+3/256, tie -> RNE 0x3F82.
- Single beat 0x0000 with last -> 0x0000, count=1. A single 0x8000/denormal with last -> 0x0000.
- 0x3F80, 0x4000 (2.0, last) -> 0x7F80, out_ovf_o=1, count=2. An input of 0x7FC0 (NaN) gives the same.
- MAX_LEN=8: 9 beats of 0x3F80, no last -> after the 8th, in_ready_o=0, result 0x4100 (8.0), count=8, out_trunc_o=1. The 9th beat is held by the source and starts the next vector after the handshake.
- Backpressure and clear:
  - out_ready_i low for 5 cycles -> outputs stable, in_ready_o=0.
  - clear_i after 2 of 4 beats -> IDLE with no output. A following 1-beat vector of 0x3F00 -> 0x3F00, count=1.
